usr_seq: RTL and testbench

- Parametrised universal shift register (hold / shift right / shift left / parallel load) of WIDTH bits.
- Adds a multi-cycle "shift by N" command sequencer with a busy/done handshake and serial outputs at both ends.
- Successor to the fixed 4-bit mux+DFF register. Used wherever a datapath needs programmable serialisation or bit alignment.

---
 rtl/usr_seq.sv | 128 ++++++++++++
 tb/tb_usr_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/usr_seq.sv
// Universal shift register with a multi-cycle "shift by N" command sequencer.
// Optional circular shifting is compiled in with `define USR_SEQ_ROTATE_EN.
module usr_seq #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             ser_in_msb,
    input  logic             ser_in_lsb,
    input  logic [WIDTH-1:0] d,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic             rotate,
    output logic [WIDTH-1:0] q,
    output logic             so_lsb,
    output logic             so_msb,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] q_next;
    logic [AMT_W-1:0] remaining, rem_next;
    logic             dir_left, dir_next;
    logic             man_rot, cmd_rot;

`ifdef USR_SEQ_ROTATE_EN
    logic rot_lat, rot_next;
    assign man_rot = rotate;
    assign cmd_rot = rot_lat;
`else
    logic rotate_unused;
    assign rotate_unused = rotate;
    assign man_rot = 1'b0;
    assign cmd_rot = 1'b0;
`endif

    // One shift step; with rot set the bit falling off one end re-enters the other.
    function automatic logic [WIDTH-1:0] shift_once(
        input logic [WIDTH-1:0] v,
        input logic             left,
        input logic             rot,
        input logic             in_msb,
        input logic             in_lsb
    );
        if (left)
            return {v[WIDTH-2:0], (rot ? v[WIDTH-1] : in_lsb)};
        else
            return {(rot ? v[0] : in_msb), v[WIDTH-1:1]};
    endfunction

    always_comb begin
        state_next = state;
        q_next     = q;
        rem_next   = remaining;
        dir_next   = dir_left;
`ifdef USR_SEQ_ROTATE_EN
        rot_next   = rot_lat;
`endif
        case (state)
            IDLE: begin
                if (start && (mode == 2'b01 || mode == 2'b10)) begin
                    dir_next   = mode[1];
                    rem_next   = amount;
`ifdef USR_SEQ_ROTATE_EN
                    rot_next   = rotate;
`endif
                    state_next = (amount == '0) ? DONE : SHIFT;
                end else if (en) begin
                    case (mode)
                        2'b01:   q_next = shift_once(q, 1'b0, man_rot, ser_in_msb, ser_in_lsb);
                        2'b10:   q_next = shift_once(q, 1'b1, man_rot, ser_in_msb, ser_in_lsb);
                        2'b11:   q_next = d;
                        default: q_next = q;
                    endcase
                end
            end
            SHIFT: begin
                // Serial inputs are live here; only direction and rotate were latched.
                q_next   = shift_once(q, dir_left, cmd_rot, ser_in_msb, ser_in_lsb);
                rem_next = remaining - AMT_W'(1);
                if (remaining == AMT_W'(1))
                    state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state     <= IDLE;
            q         <= '0;
            remaining <= '0;
            dir_left  <= 1'b0;
`ifdef USR_SEQ_ROTATE_EN
            rot_lat   <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            q         <= q_next;
            remaining <= rem_next;
            dir_left  <= dir_next;
`ifdef USR_SEQ_ROTATE_EN
            rot_lat   <= rot_next;
`endif
        end
    end

    assign busy   = (state == SHIFT);
    assign done   = (state == DONE);
    assign so_lsb = q[0];
    assign so_msb = q[WIDTH-1];

endmodule

// File: tb/tb_usr_seq.sv
// Directed bench for usr_seq (WIDTH=8, AMT_W=4); rotate expectations follow
// whether USR_SEQ_ROTATE_EN is defined for the build.
module tb_usr_seq;

    logic       clk = 1'b0;
    logic       clear_n, en, ser_in_msb, ser_in_lsb, start, rotate;
    logic [1:0] mode;
    logic [7:0] d;
    logic [3:0] amount;
    logic [7:0] q;
    logic       so_lsb, so_msb, busy, done;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    usr_seq #(.WIDTH(8), .AMT_W(4)) dut (
        .clk(clk), .clear_n(clear_n), .en(en), .mode(mode),
        .ser_in_msb(ser_in_msb), .ser_in_lsb(ser_in_lsb), .d(d),
        .start(start), .amount(amount), .rotate(rotate),
        .q(q), .so_lsb(so_lsb), .so_msb(so_msb), .busy(busy), .done(done)
    );

    // clock / reset
    always #5 clk = ~clk;

    // Inputs change just after a falling edge; outputs are sampled at the next falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        en = 0; mode = 2'b00; start = 0; amount = 0; rotate = 0;
        ser_in_msb = 0; ser_in_lsb = 0; d = 8'h00;
    endtask

    task automatic load(input logic [7:0] val);
        en = 1; mode = 2'b11; d = val; start = 0;
        tick();
        en = 0; mode = 2'b00;
    endtask

    initial begin
        idle_inputs();
        clear_n = 1;
        @(negedge clk);

        // random activity, then reset held two cycles
        for (int i = 0; i < 6; i++) begin
            en = 1; mode = 2'($urandom_range(0, 3)); d = 8'($urandom_range(0, 255));
            ser_in_msb = 1'($urandom_range(0, 1)); ser_in_lsb = 1'($urandom_range(0, 1));
            tick();
        end
        start = 1; mode = 2'b01; amount = 4'd9;
        tick();
        clear_n = 0; idle_inputs();
        tick(); tick();
        check("rst_q", q, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_so_lsb", so_lsb, 0);
        check("rst_so_msb", so_msb, 0);
        clear_n = 1;

        // manual operations
        load(8'hA5);
        check("man_load", q, 8'hA5);
        en = 1; mode = 2'b01; ser_in_msb = 1;
        tick();
        check("man_right", q, 8'hD2);
        check("man_right_so_lsb", so_lsb, 0);
        check("man_right_so_msb", so_msb, 1);
        mode = 2'b10; ser_in_lsb = 1;
        tick();
        check("man_left", q, 8'hA5);
        mode = 2'b00;
        tick();
        check("man_hold", q, 8'hA5);
        en = 0; mode = 2'b11; d = 8'h3C;
        tick();
        check("en_low_hold", q, 8'hA5);
        idle_inputs();

        // left command, amount 3; en/mode/d churn while busy
        load(8'h81);
        start = 1; mode = 2'b10; amount = 4'd3; ser_in_lsb = 0;
        exp_q.push_back(8'h81); exp_q.push_back(8'h02); exp_q.push_back(8'h04);
        tick();
        start = 0; en = 1; mode = 2'b11; d = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            exp_v = exp_q.pop_front();
            check("cmd3_busy_q", q, exp_v);
            check("cmd3_busy", busy, 1);
            check("cmd3_no_done", done, 0);
            mode = (i == 0) ? 2'b01 : 2'b11;
            tick();
        end
        check("cmd3_done_q", q, 8'h08);
        check("cmd3_done", done, 1);
        check("cmd3_done_busy", busy, 0);
        tick();
        check("cmd3_idle_q", q, 8'h08);
        check("cmd3_idle_done", done, 0);
        idle_inputs();

        // zero-length command
        start = 1; mode = 2'b01; amount = 4'd0; ser_in_msb = 1;
        tick();
        start = 0;
        check("amt0_busy", busy, 0);
        check("amt0_done", done, 1);
        check("amt0_q", q, 8'h08);
        tick();
        check("amt0_idle_done", done, 0);
        check("amt0_idle_q", q, 8'h08);

        // start held high through SHIFT and DONE is ignored
        start = 1; mode = 2'b01; amount = 4'd2; ser_in_msb = 0;
        tick();
        mode = 2'b10; amount = 4'd5;
        check("sh_ign_q0", q, 8'h08);
        tick();
        check("sh_ign_q1", q, 8'h04);
        check("sh_ign_busy", busy, 1);
        tick();
        check("sh_ign_done", done, 1);
        check("sh_ign_q2", q, 8'h02);
        tick();
        check("dn_ign_busy", busy, 0);
        check("dn_ign_done", done, 0);
        check("dn_ign_q", q, 8'h02);
        idle_inputs();

        // amount larger than WIDTH fills from the serial input
        load(8'h00);
        start = 1; mode = 2'b01; amount = 4'd10; ser_in_msb = 1;
        tick();
        start = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_v = (k >= 8) ? 8'hFF : 8'(8'hFF << (8 - k));
            check("fill_q", q, exp_v);
            check("fill_busy", busy, (k < 10) ? 1 : 0);
            check("fill_done", done, (k == 10) ? 1 : 0);
        end
        tick();
        check("fill_idle_q", q, 8'hFF);

        // abort mid-command with clear_n
        load(8'h00);
        start = 1; mode = 2'b01; amount = 4'd10; ser_in_msb = 1;
        tick();
        start = 0;
        for (int k = 0; k < 4; k++) tick();
        check("abort_pre_q", q, 8'hF0);
        clear_n = 0;
        tick();
        check("abort_q", q, 8'h00);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        clear_n = 1;
        tick();
        check("abort_no_done", done, 0);
        check("abort_idle_busy", busy, 0);
        idle_inputs();

        // rotate select (latched at start for commands)
        load(8'h81);
        en = 1; mode = 2'b01; rotate = 1; ser_in_msb = 0;
        tick();
        en = 0;
`ifdef USR_SEQ_ROTATE_EN
        check("rot_man_right", q, 8'hC0);
`else
        check("rot_man_right", q, 8'h40);
`endif
        start = 1; mode = 2'b10; amount = 4'd8; ser_in_lsb = 0;
        tick();
        start = 0; rotate = 0;
        for (int k = 0; k < 8; k++) tick();
        check("rot_cmd_done", done, 1);
`ifdef USR_SEQ_ROTATE_EN
        check("rot_cmd_q", q, 8'hC0);
`else
        check("rot_cmd_q", q, 8'h00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
